// File: rtl/rr_arbiter_8_if.sv
// rr_arbiter_8_if
// Request/grant bundle between the requesters and the round-robin arbiter.
//   en        : global enable (driven by master side)
//   req[7:0]  : level-sensitive request lines, bit k = requester k
//   gnt[7:0]  : registered one-hot grant
//   gnt_id    : registered encoded owner index (0 when idle)
//   gnt_valid : registered |gnt
//   timeout   : registered one-cycle pulse on a forced rotation/renewal
interface rr_arbiter_8_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    // Requester side drives requests and observes grants.
    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  timeout
    );

    // Arbiter side observes requests and drives grants.
    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8
// Eight-way round-robin arbiter with grant hold and optional hold timeout.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all outputs immediately
//   bus   : rr_arbiter_8_if.slave (en, req in; gnt, gnt_id, gnt_valid, timeout out)
// Parameter:
//   MAX_HOLD : max consecutive grant cycles per owner (0..255, 0 = no timeout)
// All outputs are direct flop outputs; nothing combinational reaches them
// from req or en.
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_arbiter_8_if.slave    bus
);

    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);
    localparam bit         TO_ENABLE  = (MAX_HOLD != 0);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_r, state_s;
    logic [7:0] gnt_r, gnt_s;
    // gnt_id_r doubles as the owner register: it equals k whenever GRANT.
    logic [2:0] gnt_id_r, gnt_id_s;
    logic       gnt_valid_r, gnt_valid_s;
    logic       timeout_r, timeout_s;
    logic [2:0] ptr_r, ptr_s;
    logic [7:0] hcnt_r, hcnt_s;
    logic [2:0] next_ptr_s;
    logic [7:0] others_s;
    logic       hold_limit_s;

    // First index with mask bit set, scanning start, start+1, ... mod 8.
    function automatic logic [2:0] pick(input logic [7:0] mask, input logic [2:0] start);
        logic [2:0] idx;
        logic [2:0] res;
        logic       found;
        res   = start;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = start + 3'(i);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] onehot(input logic [2:0] idx);
        return 8'd1 << idx;
    endfunction

    // Next-state and next-output computation for the IDLE/GRANT machine.
    always_comb begin
        state_s      = state_r;
        gnt_id_s     = gnt_id_r;
        ptr_s        = ptr_r;
        hcnt_s       = hcnt_r;
        timeout_s    = 1'b0;
        next_ptr_s   = gnt_id_r + 3'd1;
        others_s     = bus.req & ~gnt_r;
        hold_limit_s = TO_ENABLE && (hcnt_r == MAX_HOLD_C);
        case (state_r)
            IDLE: begin
                if (bus.en && (|bus.req)) begin
                    gnt_id_s = pick(bus.req, ptr_r);
                    hcnt_s   = 8'd1;
                    state_s  = GRANT;
                end else begin
                    gnt_id_s = 3'd0;
                    state_s  = IDLE;
                end
            end
            GRANT: begin
                if (!bus.req[gnt_id_r]) begin
                    // Release: pointer moves past the old owner, handover
                    // happens in the same edge when someone else is asking.
                    ptr_s = next_ptr_s;
                    if (bus.en && (|bus.req)) begin
                        gnt_id_s = pick(bus.req, next_ptr_s);
                        hcnt_s   = 8'd1;
                    end else begin
                        gnt_id_s = 3'd0;
                        hcnt_s   = 8'd0;
                        state_s  = IDLE;
                    end
                end else if (hold_limit_s) begin
                    timeout_s = 1'b1;
                    ptr_s     = next_ptr_s;
                    if (!bus.en) begin
                        gnt_id_s = 3'd0;
                        hcnt_s   = 8'd0;
                        state_s  = IDLE;
                    end else if (|others_s) begin
                        gnt_id_s = pick(others_s, next_ptr_s);
                        hcnt_s   = 8'd1;
                    end else begin
                        // Sole requester: renew its grant.
                        hcnt_s = 8'd1;
                    end
                end else begin
                    if (hcnt_r != 8'hFF) begin
                        hcnt_s = hcnt_r + 8'd1;
                    end else begin
                        hcnt_s = hcnt_r;
                    end
                end
            end
            default: begin
                state_s  = IDLE;
                gnt_id_s = 3'd0;
                hcnt_s   = 8'd0;
            end
        endcase
        gnt_s       = (state_s == GRANT) ? onehot(gnt_id_s) : 8'd0;
        gnt_valid_s = (state_s == GRANT);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            gnt_r       <= 8'd0;
            gnt_id_r    <= 3'd0;
            gnt_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
            ptr_r       <= 3'd0;
            hcnt_r      <= 8'd0;
        end else begin
            state_r     <= state_s;
            gnt_r       <= gnt_s;
            gnt_id_r    <= gnt_id_s;
            gnt_valid_r <= gnt_valid_s;
            timeout_r   <= timeout_s;
            ptr_r       <= ptr_s;
            hcnt_r      <= hcnt_s;
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_id    = gnt_id_r;
    assign bus.gnt_valid = gnt_valid_r;
    assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb_rr_arbiter_8
// Self-checking bench for rr_arbiter_8 (MAX_HOLD=4): a constant vector
// table, hand-written reset/rotation/timeout sequences and a randomized
// run compared against a behavioural model of the arbitration rules.
module tb_rr_arbiter_8;

    localparam int MAXH = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    rr_arbiter_8_if bus ();

    rr_arbiter_8 #(.MAX_HOLD(MAXH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: owner is -1 when idle.
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_to;

    function automatic int scan(input logic [7:0] mask, input int start);
        for (int i = 0; i < 8; i++) begin
            if (mask[(start + i) % 8]) return (start + i) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic en, input logic [7:0] req);
        logic [7:0] others;
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (en && req != 8'd0) begin
                m_owner = scan(req, m_ptr);
                m_hold  = 1;
            end
        end else if (!req[m_owner]) begin
            m_ptr = (m_owner + 1) % 8;
            if (en && req != 8'd0) begin
                m_owner = scan(req, m_ptr);
                m_hold  = 1;
            end else begin
                m_owner = -1;
            end
        end else if (MAXH != 0 && m_hold == MAXH) begin
            m_to  = 1'b1;
            m_ptr = (m_owner + 1) % 8;
            if (!en) begin
                m_owner = -1;
            end else begin
                others = req & ~(8'd1 << m_owner);
                if (others != 8'd0) m_owner = scan(others, m_ptr);
                m_hold = 1;
            end
        end else begin
            m_hold = m_hold + 1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        model_step(bus.en, bus.req);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_outs(input string nm, input logic [7:0] g, input logic [2:0] id, input logic to);
        chk({nm, ".gnt"}, 32'(bus.gnt), 32'(g));
        chk({nm, ".gnt_id"}, 32'(bus.gnt_id), 32'(id));
        chk({nm, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(g != 8'd0));
        chk({nm, ".timeout"}, 32'(bus.timeout), 32'(to));
    endtask

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] id;
        logic       to;
    } vec_t;

    vec_t tbl[23];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] g_exp;
        logic [7:0] r;
        errors  = 0;
        checks  = 0;
        rst_n   = 1'b0;
        bus.en  = 1'b0;
        bus.req = 8'd0;
        model_reset();

        // Handover, wrap-around, single-requester timeout, enable gating,
        // timeout with a waiting requester; one vector per clock edge.
        tbl[0]  = '{1'b1, 8'h05, 8'h01, 3'd0, 1'b0};
        tbl[1]  = '{1'b1, 8'h05, 8'h01, 3'd0, 1'b0};
        tbl[2]  = '{1'b1, 8'h05, 8'h01, 3'd0, 1'b0};
        tbl[3]  = '{1'b1, 8'h04, 8'h04, 3'd2, 1'b0};
        tbl[4]  = '{1'b1, 8'h04, 8'h04, 3'd2, 1'b0};
        tbl[5]  = '{1'b1, 8'h20, 8'h20, 3'd5, 1'b0};
        tbl[6]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[7]  = '{1'b1, 8'h21, 8'h01, 3'd0, 1'b0};
        tbl[8]  = '{1'b1, 8'h20, 8'h20, 3'd5, 1'b0};
        tbl[9]  = '{1'b1, 8'h20, 8'h20, 3'd5, 1'b0};
        tbl[10] = '{1'b1, 8'h20, 8'h20, 3'd5, 1'b0};
        tbl[11] = '{1'b1, 8'h20, 8'h20, 3'd5, 1'b0};
        tbl[12] = '{1'b1, 8'h20, 8'h20, 3'd5, 1'b1};
        tbl[13] = '{1'b1, 8'h20, 8'h20, 3'd5, 1'b0};
        tbl[14] = '{1'b0, 8'h20, 8'h20, 3'd5, 1'b0};
        tbl[15] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[16] = '{1'b0, 8'h10, 8'h00, 3'd0, 1'b0};
        tbl[17] = '{1'b1, 8'h10, 8'h10, 3'd4, 1'b0};
        tbl[18] = '{1'b1, 8'h11, 8'h10, 3'd4, 1'b0};
        tbl[19] = '{1'b1, 8'h11, 8'h10, 3'd4, 1'b0};
        tbl[20] = '{1'b1, 8'h11, 8'h10, 3'd4, 1'b0};
        tbl[21] = '{1'b1, 8'h11, 8'h01, 3'd0, 1'b1};
        tbl[22] = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b0};

        do_reset();
        chk_outs("reset", 8'h00, 3'd0, 1'b0);

        for (int i = 0; i < 23; i++) begin
            bus.en  = tbl[i].en;
            bus.req = tbl[i].req;
            tick();
            chk_outs($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].id, tbl[i].to);
        end

        // Reset mid-grant: outputs must clear without a clock edge.
        do_reset();
        bus.en  = 1'b1;
        bus.req = 8'h08;
        tick();
        chk_outs("rst_pre", 8'h08, 3'd3, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_outs("rst_async", 8'h00, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk_outs("rst_regrant", 8'h08, 3'd3, 1'b0);
        do_reset();
        bus.req = 8'h09;
        tick();
        chk_outs("rst_ptr0", 8'h01, 3'd0, 1'b0);

        // Full rotation with all requesting: each owner 4 cycles.
        do_reset();
        bus.en  = 1'b1;
        bus.req = 8'hFF;
        for (int c = 0; c < 36; c++) begin
            tick();
            g_exp = 8'd1 << ((c / MAXH) % 8);
            chk_outs($sformatf("rot%0d", c), g_exp, 3'((c / MAXH) % 8), (c > 0) && (c % MAXH == 0));
        end

        // Single requester: grant held, timeout pulse every 4 cycles.
        do_reset();
        bus.en  = 1'b1;
        bus.req = 8'h08;
        for (int c = 0; c < 17; c++) begin
            tick();
            chk_outs($sformatf("solo%0d", c), 8'h08, 3'd3, (c > 0) && (c % MAXH == 0));
        end

        // Randomized run against the model.
        do_reset();
        r = 8'd0;
        for (int c = 0; c < 3000; c++) begin
            case ($urandom_range(0, 9))
                0:       r = 8'($urandom);
                1:       r = 8'($urandom) & 8'($urandom);
                2:       r = r ^ (8'd1 << $urandom_range(0, 7));
                3:       r = 8'($urandom) | 8'($urandom);
                default: r = r;
            endcase
            bus.req = r;
            bus.en  = ($urandom_range(0, 7) != 0);
            tick();
            g_exp = (m_owner < 0) ? 8'd0 : (8'd1 << m_owner);
            chk_outs("rand", g_exp, (m_owner < 0) ? 3'd0 : 3'(m_owner), m_to);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
